// File: rtl/stage_fetch.sv
// stage_fetch: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC and keeps at most one instruction-memory request in flight.
// A one-entry hold buffer catches a response that lands while IF/ID is stalled.
// Optional feature macro: STAGE_FETCH_MISALIGN_CHECK_EN.
//   Defined   -> a PC with pc[1:0] != 0 raises exception 001 and halts fetch.
//   Undefined -> pc[1:0] is ignored and the word-aligned address is fetched.
module stage_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_1000,
  parameter logic [31:0] EXC_VECTOR_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_pc_write_disable,
  input  logic        in_IFID_write_disable,
  input  logic        in_branch_taken,
  input  logic [31:0] in_branch_target,
  input  logic        in_exception_flush,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_valid,
  input  logic [31:0] in_imem_data,
  input  logic        in_imem_error,
  output logic [31:0] out_instruction,
  output logic [31:0] out_PC,
  output logic [2:0]  out_exception_vector
);

  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam logic [2:0]  EXC_NONE      = 3'b000;
  localparam logic [2:0]  EXC_MISALIGN  = 3'b001;
  localparam logic [2:0]  EXC_ACCESS    = 3'b010;

  // WAIT: our request is outstanding. KILL: outstanding request was flushed,
  // its response must be swallowed. HALT: parked after a faulting fetch.
  typedef enum logic [1:0] {FETCH, WAIT, KILL, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic [2:0]  hold_exc;

  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_addr;
  logic        misaligned;
  logic        fetch_ok;
  logic        issue;
  logic        misalign_fault;
  logic        accept;
  logic        prod_valid;
  logic [31:0] prod_instr;
  logic [2:0]  prod_exc;

`ifdef STAGE_FETCH_MISALIGN_CHECK_EN
  assign fetch_addr = pc;
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign fetch_addr = {pc[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  // Redirect select: exception flush outranks a branch.
  assign flush    = in_exception_flush | in_branch_taken;
  assign flush_pc = in_exception_flush ? EXC_VECTOR_PC : in_branch_target;

  // A new fetch may start only from FETCH with the PC unlocked, nothing parked
  // in the hold buffer and no redirect arriving this cycle.
  assign fetch_ok       = (state == FETCH) && !in_pc_write_disable && !hold_valid
                          && !flush && !reset;
  assign issue          = fetch_ok && !misaligned;
  assign misalign_fault = fetch_ok && misaligned;

  // The request is a level: raised on issue and kept up (with the captured
  // address) until the memory answers, even across a flush.
  assign out_imem_req  = !reset && (issue || (state == WAIT) || (state == KILL));
  assign out_imem_addr = (state == FETCH) ? fetch_addr : req_addr;

  // A response is used only if it belongs to a live request and no redirect
  // is discarding it in the same cycle.
  assign accept     = out_imem_req && in_imem_valid && (state != KILL) && !flush;
  assign prod_valid = accept || misalign_fault;

  // Entry produced for IF/ID this cycle: the fetched word, or a NOP carrying
  // the fault code. out_imem_addr equals the PC of whatever is being produced.
  always_comb begin
    prod_instr = NOP;
    prod_exc   = EXC_NONE;
    if (misalign_fault) begin
      prod_exc = EXC_MISALIGN;
    end else if (in_imem_error) begin
      prod_exc = EXC_ACCESS;
    end else begin
      prod_instr = in_imem_data;
    end
  end

  // PC, request bookkeeping, hold buffer, IF/ID register and the fetch FSM.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would let later lines see new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= FETCH;
      pc                   <= RESET_PC;
      req_addr             <= RESET_PC;
      hold_valid           <= 1'b0;
      hold_instr           <= NOP;
      hold_pc              <= '0;
      hold_exc             <= EXC_NONE;
      out_instruction      <= NOP;
      out_PC               <= '0;
      out_exception_vector <= EXC_NONE;
    end else if (flush) begin
      pc                   <= flush_pc;
      hold_valid           <= 1'b0;
      out_instruction      <= NOP;
      out_PC               <= '0;
      out_exception_vector <= EXC_NONE;
      if (((state == WAIT) || (state == KILL)) && !in_imem_valid)
        state <= KILL;
      else
        state <= FETCH;
    end else begin
      if (issue)
        req_addr <= fetch_addr;
      if (accept)
        pc <= pc + 32'd4;

      if (!in_IFID_write_disable) begin
        if (hold_valid) begin
          out_instruction      <= hold_instr;
          out_PC               <= hold_pc;
          out_exception_vector <= hold_exc;
          hold_valid           <= 1'b0;
        end else if (prod_valid) begin
          out_instruction      <= prod_instr;
          out_PC               <= out_imem_addr;
          out_exception_vector <= prod_exc;
        end else begin
          out_instruction      <= NOP;
          out_PC               <= '0;
          out_exception_vector <= EXC_NONE;
        end
      end else if (prod_valid) begin
        hold_instr <= prod_instr;
        hold_pc    <= out_imem_addr;
        hold_exc   <= prod_exc;
        hold_valid <= 1'b1;
      end

      case (state)
        FETCH: begin
          if (misalign_fault)
            state <= HALT;
          else if (issue)
            state <= in_imem_valid ? (in_imem_error ? HALT : FETCH) : WAIT;
        end
        WAIT: begin
          if (in_imem_valid)
            state <= in_imem_error ? HALT : FETCH;
        end
        KILL: begin
          if (in_imem_valid)
            state <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
